song_reader: RTL and testbench
==============================

SONG_READER -- requirements
Module: song_reader

Interface
REQ-001 Parameter NOTES_PER_SONG, default 32, SHALL set the maximum number of note entries per song; it SHALL be a power of two.
REQ-002 Parameter SONG_COUNT, default 4, SHALL set the number of selectable songs; it SHALL be a power of two.
REQ-003 Port clk, input, 1 bit, SHALL be the single system clock; all state SHALL change on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be an asynchronous, active-high reset.
REQ-005 Port play, input, 1 bit: high means playback runs; low means playback pauses.
REQ-006 Port song, input, log2(SONG_COUNT) bits, SHALL select the active song.
REQ-007 Port note_done, input, 1 bit, SHALL be the note player's done_with_note level.
REQ-008 Port note, output, 6 bits, SHALL be the note number to load.
REQ-009 Port duration, output, 6 bits, SHALL be the duration to load, in 1/48 s beats.
REQ-010 Port new_note, output, 1 bit, SHALL be a one-cycle load strobe to the note player.
REQ-011 Port song_done, output, 1 bit, SHALL indicate that the end of the song was reached.

Function
REQ-012 The FSM SHALL have the states IDLE, FETCH, LOAD, ACK, WAIT and END.
REQ-013 The ROM address SHALL be {song_q, idx}, where idx is a log2(NOTES_PER_SONG)-bit note index and the data word is {note[11:6], duration[5:0]}.
REQ-014 IDLE: the FSM SHALL go to FETCH when play=1; otherwise it SHALL hold.
REQ-015 FETCH: the FSM SHALL present the address and go to LOAD on the next cycle (the ROM has one cycle of read latency).
REQ-016 LOAD, ROM duration != 0: the FSM SHALL register note and duration, assert new_note for exactly this cycle, and go to ACK.
REQ-017 LOAD, ROM duration == 0: this is the end-of-song marker; the FSM SHALL go to END, new_note SHALL stay low, and note/duration SHALL hold their values.
REQ-018 ACK: the FSM SHALL go to WAIT unconditionally; this skips the single cycle before note_done deasserts.
REQ-019 WAIT: when note_done=1 and play=1, the FSM SHALL go to END if idx == NOTES_PER_SONG-1; otherwise it SHALL increment idx and go to FETCH.
REQ-020 While play=0, the FSM SHALL hold in IDLE or WAIT; FETCH, LOAD and ACK SHALL always complete, so a handshake is never split.
REQ-021 Latency from play first sampled high in IDLE (cycle N) to new_note SHALL be: new_note high in cycle N+2.
REQ-022 Latency from note_done sampled high in WAIT (cycle M) to the next new_note SHALL be: new_note high in cycle M+2.
REQ-023 song_q SHALL register song every cycle.
REQ-024 If song != song_q in any state, then on the next cycle idx SHALL be 0, the state SHALL be IDLE, and song_done SHALL be 0; this takes priority over all other transitions.
REQ-025 If a song change and note_done occur in the same cycle, the song change SHALL win.
REQ-026 idx SHALL never exceed NOTES_PER_SONG-1; it SHALL have no wrap path except REQ-030.

Reset
REQ-027 On reset, the following SHALL clear asynchronously and stay cleared while reset=1: state=IDLE, idx=0, song_q=song input, note=0, duration=0, new_note=0, song_done=0.
REQ-028 Reset asserted mid-handshake SHALL drop new_note immediately.

Configuration
REQ-029 Without macro SONG_LOOP_EN: END SHALL hold song_done=1 until reset or a song change, and no further notes SHALL be loaded.
REQ-030 With macro SONG_LOOP_EN defined: END SHALL assert song_done for exactly one cycle, clear idx to 0 and go to FETCH, so the song loops.

Structure
REQ-031 A shared package SHALL hold the state encoding constants, the note and duration widths (6), the ROM word width (12), and the end-of-song marker value.
REQ-032 The block SHALL contain one sub-module, song_rom: synchronous, registered output, depth SONG_COUNT*NOTES_PER_SONG, 12-bit words.

Verification
REQ-033 Reset, then play=1, song=0 with ROM[0]={6'd20,6'd5}: the bench SHALL see new_note high 2 cycles later with note=20 and duration=5; song_done=0.
REQ-034 Hold note_done=1 in WAIT with idx=3: the bench SHALL see the next new_note 2 cycles later carrying ROM[4]; the bench SHALL see idx=4.
REQ-035 Drive play=0 during WAIT, with note_done=1, for 10 cycles: the bench SHALL see no new_note; after play=1, new_note SHALL follow 2 cycles later.
REQ-036 ROM[2] duration=0: after note 1 completes, the bench SHALL see song_done=1 and no new_note. With SONG_LOOP_EN, the bench SHALL see a 1-cycle song_done pulse followed by a reload of ROM[0].
REQ-037 Full 32-note song with no marker: after idx=31 completes, the bench SHALL see END reached and idx not wrapped (macro off).
REQ-038 Change song 0 to 2 during WAIT, together with note_done=1: the bench SHALL see IDLE next cycle with idx=0, and the next new_note SHALL carry ROM[64].

Source files
------------

// File: rtl/song_reader_pkg.sv
// Shared widths, FSM state encoding and the built-in song table for song_reader.
// The optional SONG_LOOP_EN build macro only affects rtl/song_reader.sv.
package song_reader_pkg;

    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;
    localparam int ROM_W  = NOTE_W + DUR_W;

    // A zero duration terminates a song early.
    localparam logic [DUR_W-1:0]  END_MARKER  = '0;
    localparam logic [NOTE_W-1:0] MARKER_NOTE = 6'd63;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_ACK   = 3'd3,
        ST_WAIT  = 3'd4,
        ST_END   = 3'd5
    } state_t;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  duration;
    } rom_word_t;

    // Song table contents, repeating every four songs:
    //   song 0: full-length scale, note 20+i, duration 5..8
    //   song 1: two notes then the end marker at index 2
    //   song 2: six notes (10, 12, 14, ...) then the end marker
    //   song 3: end marker at index 0 (empty song)
    function automatic rom_word_t song_table(input int unsigned song_i, input int unsigned idx_i);
        rom_word_t w;
        w.note     = MARKER_NOTE;
        w.duration = END_MARKER;
        case (song_i % 4)
            0: begin
                w.note     = NOTE_W'(20 + idx_i);
                w.duration = DUR_W'(5 + (idx_i % 4));
            end
            1: begin
                if (idx_i != 2) begin
                    w.note     = NOTE_W'(30 + idx_i);
                    w.duration = DUR_W'(3);
                end
            end
            2: begin
                if (idx_i != 6) begin
                    w.note     = NOTE_W'(10 + 2 * idx_i);
                    w.duration = DUR_W'(12);
                end
            end
            default: begin
                if (idx_i != 0) begin
                    w.note     = NOTE_W'(1);
                    w.duration = DUR_W'(1);
                end
            end
        endcase
        return w;
    endfunction

endpackage

// File: rtl/song_rom.sv
// Song table ROM: SONG_COUNT*NOTES_PER_SONG words of {note, duration},
// addressed by {song, idx}, with one cycle of registered read latency.
module song_rom
    import song_reader_pkg::*;
#(
    parameter int NOTES_PER_SONG = 32,
    parameter int SONG_COUNT     = 4
) (
    input  logic                                         clk,
    input  logic [$clog2(SONG_COUNT*NOTES_PER_SONG)-1:0] i_addr,
    output logic [ROM_W-1:0]                             o_rom_data
);

    localparam int DEPTH = SONG_COUNT * NOTES_PER_SONG;

    logic [ROM_W-1:0] w_rom [DEPTH];
    logic [ROM_W-1:0] r_rom_data;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_rom
            assign w_rom[gi] = song_table(gi / NOTES_PER_SONG, gi % NOTES_PER_SONG);
        end
    endgenerate

    always_ff @(posedge clk) begin
        r_rom_data <= w_rom[i_addr];
    end

    assign o_rom_data = r_rom_data;

endmodule

// File: rtl/song_reader.sv
// Song reader: walks the selected song in the ROM and hands notes to the note player.
// Build macro SONG_LOOP_EN: when defined the song restarts after END instead of stopping.
module song_reader
    import song_reader_pkg::*;
#(
    parameter int NOTES_PER_SONG = 32,
    parameter int SONG_COUNT     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          play,
    input  logic [$clog2(SONG_COUNT)-1:0] song,
    input  logic                          note_done,
    output logic [NOTE_W-1:0]             note,
    output logic [DUR_W-1:0]              duration,
    output logic                          new_note,
    output logic                          song_done
);

    localparam int SONG_W = $clog2(SONG_COUNT);
    localparam int IDX_W  = $clog2(NOTES_PER_SONG);
    localparam int ADDR_W = SONG_W + IDX_W;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NOTES_PER_SONG - 1);

    state_t              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [SONG_W-1:0]   r_song_q;
    logic [NOTE_W-1:0]   r_note;
    logic [DUR_W-1:0]    r_duration;
    logic                r_new_note;
    logic                r_song_done;

    logic [ADDR_W-1:0]   w_rom_addr;
    logic [ROM_W-1:0]    w_rom_data;
    logic [NOTE_W-1:0]   w_rom_note;
    logic [DUR_W-1:0]    w_rom_dur;
    logic                w_song_change;
    logic                w_idx_last;

    assign w_rom_addr    = {r_song_q, r_idx};
    assign w_rom_note    = w_rom_data[ROM_W-1:DUR_W];
    assign w_rom_dur     = w_rom_data[DUR_W-1:0];
    assign w_song_change = (song != r_song_q);
    assign w_idx_last    = (r_idx == IDX_LAST);

    song_rom #(
        .NOTES_PER_SONG (NOTES_PER_SONG),
        .SONG_COUNT     (SONG_COUNT)
    ) u_rom (
        .clk        (clk),
        .i_addr     (w_rom_addr),
        .o_rom_data (w_rom_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_song_q    <= song;
            r_note      <= '0;
            r_duration  <= '0;
            r_new_note  <= 1'b0;
            r_song_done <= 1'b0;
        end else begin
            r_song_q   <= song;
            r_new_note <= 1'b0;
            // A new song selection restarts from the top and overrides any pending handshake.
            if (w_song_change) begin
                r_state     <= ST_IDLE;
                r_idx       <= '0;
                r_song_done <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (play) begin
                            r_state <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        r_state <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        if (w_rom_dur == END_MARKER) begin
                            r_state     <= ST_END;
                            r_song_done <= 1'b1;
                        end else begin
                            r_note     <= w_rom_note;
                            r_duration <= w_rom_dur;
                            r_new_note <= 1'b1;
                            r_state    <= ST_ACK;
                        end
                    end
                    // note_done is still high from the previous note for one cycle after the strobe.
                    ST_ACK: begin
                        r_state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (note_done && play) begin
                            if (w_idx_last) begin
                                r_state     <= ST_END;
                                r_song_done <= 1'b1;
                            end else begin
                                r_idx   <= r_idx + IDX_W'(1);
                                r_state <= ST_FETCH;
                            end
                        end
                    end
                    ST_END: begin
`ifdef SONG_LOOP_EN
                        r_song_done <= 1'b0;
                        r_idx       <= '0;
                        r_state     <= ST_FETCH;
`else
                        r_song_done <= 1'b1;
`endif
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign note      = r_note;
    assign duration  = r_duration;
    assign new_note  = r_new_note;
    assign song_done = r_song_done;

endmodule

// File: tb/tb_song_reader.sv
// Self-checking bench for song_reader: directed steps followed by random songs, checked
// against a note-sequence model of the song table. Honours SONG_LOOP_EN when defined.
module tb_song_reader;
    import song_reader_pkg::*;

    localparam int NPS = 32;
    localparam int SC  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       play = 1'b0;
    logic [1:0] song = 2'd0;
    logic       note_done = 1'b0;
    logic [5:0] note;
    logic [5:0] duration;
    logic       new_note;
    logic       song_done;

    int checks = 0;
    int errors = 0;

    song_reader #(
        .NOTES_PER_SONG (NPS),
        .SONG_COUNT     (SC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .play      (play),
        .song      (song),
        .note_done (note_done),
        .note      (note),
        .duration  (duration),
        .new_note  (new_note),
        .song_done (song_done)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // Expected song contents, written out from the song descriptions.
    function automatic int model_note(input int s, input int i);
        if (s == 0) return (20 + i) % 64;
        if (s == 1) return 30 + i;
        if (s == 2) return 10 + 2 * i;
        return 1;
    endfunction

    function automatic int model_dur(input int s, input int i);
        if (s == 0) return 5 + (i % 4);
        if (s == 1) return (i == 2) ? 0 : 3;
        if (s == 2) return (i == 6) ? 0 : 12;
        return (i == 0) ? 0 : 1;
    endfunction

    // Number of playable notes before the marker (or the whole song).
    function automatic int model_len(input int s);
        for (int i = 0; i < NPS; i++) begin
            if (model_dur(s, i) == 0) return i;
        end
        return NPS;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges from the one that samples the stimulus (k=0) until new_note shows.
    task automatic wait_note(input int limit, output int lat, output logic [5:0] n, output logic [5:0] d);
        lat = -1;
        n   = '0;
        d   = '0;
        for (int k = 0; k < limit; k++) begin
            tick();
            if (k == 0) note_done = 1'b0;
            if (new_note === 1'b1) begin
                lat = k;
                n   = note;
                d   = duration;
                break;
            end
        end
    endtask

    task automatic expect_note(input int s, input int i);
        int lat;
        logic [5:0] n;
        logic [5:0] d;
        wait_note(8, lat, n, d);
        chk($sformatf("lat_s%0d_i%0d", s, i), lat, 2);
        chk($sformatf("note_s%0d_i%0d", s, i), n, model_note(s, i));
        chk($sformatf("dur_s%0d_i%0d", s, i), d, model_dur(s, i));
        chk($sformatf("idx_s%0d_i%0d", s, i), dut.r_idx, i);
        $display("note song=%0d idx=%0d note=%0d dur=%0d lat=%0d", s, i, n, d, lat);
        tick();
        chk($sformatf("pulse_s%0d_i%0d", s, i), new_note, 0);
    endtask

    // Random idle time in WAIT, sometimes with play paused while note_done is high.
    task automatic gap();
        int quiet = $urandom_range(0, 2);
        int seen = 0;
        note_done = 1'b0;
        for (int k = 0; k < quiet; k++) begin
            tick();
            if (new_note === 1'b1) seen++;
        end
        if ($urandom_range(0, 2) == 0) begin
            play = 1'b0;
            note_done = 1'b1;
            repeat ($urandom_range(1, 4)) begin
                tick();
                if (new_note === 1'b1) seen++;
            end
            chk("pause_state", 32'(dut.r_state), 32'(ST_WAIT));
            play = 1'b1;
        end
        chk("gap_no_note", seen, 0);
    endtask

    task automatic wait_end(input int limit, output int lat, output int notes_seen);
        lat = -1;
        notes_seen = 0;
        for (int k = 0; k < limit; k++) begin
            tick();
            if (k == 0) note_done = 1'b0;
            if (new_note === 1'b1) notes_seen++;
            if (song_done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic check_end(input int s, input int n_exp);
`ifndef SONG_LOOP_EN
        int held = 0;
        int notes = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (song_done === 1'b1) held++;
            if (new_note === 1'b1) notes++;
        end
        chk($sformatf("end_hold_s%0d", s), held, 5);
        chk($sformatf("end_silent_s%0d", s), notes, 0);
        chk($sformatf("end_state_s%0d", s), 32'(dut.r_state), 32'(ST_END));
        chk($sformatf("end_idx_s%0d", s), dut.r_idx, (n_exp == NPS) ? NPS - 1 : n_exp);
        if (n_exp > 0) begin
            chk($sformatf("end_note_hold_s%0d", s), note, model_note(s, n_exp - 1));
            chk($sformatf("end_dur_hold_s%0d", s), duration, model_dur(s, n_exp - 1));
        end
`else
        int lat;
        logic [5:0] n;
        logic [5:0] d;
        tick();
        chk($sformatf("loop_pulse_s%0d", s), song_done, 0);
        if (n_exp > 0) begin
            wait_note(4, lat, n, d);
            chk($sformatf("loop_lat_s%0d", s), lat, 1);
            chk($sformatf("loop_note_s%0d", s), n, model_note(s, 0));
            chk($sformatf("loop_dur_s%0d", s), d, model_dur(s, 0));
            tick();
        end else begin
            tick();
            tick();
            chk($sformatf("loop_redo_s%0d", s), song_done, 1);
        end
`endif
    endtask

    // Plays song s from note index 'first' (0 = start from IDLE) through to its end.
    task automatic run_song(input int s, input int first);
        int n_exp = model_len(s);
        int lat;
        int extra;
        if (first == 0) begin
            play = 1'b1;
            if (n_exp > 0) expect_note(s, 0);
        end
        for (int i = (first == 0) ? 1 : first; i < n_exp; i++) begin
            gap();
            note_done = 1'b1;
            expect_note(s, i);
        end
        if (n_exp > 0) begin
            gap();
            note_done = 1'b1;
        end
        wait_end(8, lat, extra);
        chk($sformatf("end_lat_s%0d", s), lat, (n_exp == NPS) ? 0 : 2);
        chk($sformatf("end_no_note_s%0d", s), extra, 0);
        $display("end song=%0d notes=%0d lat=%0d", s, n_exp, lat);
        check_end(s, n_exp);
    endtask

    task automatic select_song(input int s);
        play = 1'b0;
        note_done = 1'b0;
        if (song == 2'(s)) begin
            song = 2'(s ^ 1);
            tick();
        end
        song = 2'(s);
        tick();
        chk($sformatf("sel_state_s%0d", s), 32'(dut.r_state), 32'(ST_IDLE));
        chk($sformatf("sel_idx_s%0d", s), dut.r_idx, 0);
        chk($sformatf("sel_done_s%0d", s), song_done, 0);
        chk($sformatf("sel_new_note_s%0d", s), new_note, 0);
    endtask

    initial begin
        int seen;
        int lat;
        logic [5:0] n;
        logic [5:0] d;

        // Reset state
        repeat (2) tick();
        song = 2'd2;
        tick();
        chk("rst_song_q_tracks", dut.r_song_q, 2);
        song = 2'd0;
        tick();
        chk("rst_new_note", new_note, 0);
        chk("rst_song_done", song_done, 0);
        chk("rst_note", note, 0);
        chk("rst_dur", duration, 0);
        chk("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
        chk("rst_idx", dut.r_idx, 0);
        chk("rst_song_q", dut.r_song_q, 0);
        reset = 1'b0;
        tick();
        chk("idle_hold", 32'(dut.r_state), 32'(ST_IDLE));

        // First note two edges after play is sampled
        play = 1'b1;
        expect_note(0, 0);
        chk("first_song_done", song_done, 0);

        // Step to idx 3, then the next note carries entry 4
        for (int i = 1; i < 4; i++) begin
            note_done = 1'b1;
            expect_note(0, i);
        end
        chk("wait_state_idx3", 32'(dut.r_state), 32'(ST_WAIT));
        chk("wait_idx3", dut.r_idx, 3);
        note_done = 1'b1;
        expect_note(0, 4);

        // Pause in WAIT with note_done high
        play = 1'b0;
        note_done = 1'b1;
        seen = 0;
        repeat (10) begin
            tick();
            if (new_note === 1'b1) seen++;
        end
        chk("pause10_no_note", seen, 0);
        chk("pause10_state", 32'(dut.r_state), 32'(ST_WAIT));
        chk("pause10_idx", dut.r_idx, 4);
        play = 1'b1;
        expect_note(0, 5);

        // Rest of the full-length song, then END without wrapping
        run_song(0, 6);

        // Song with the end marker at index 2
        select_song(1);
        run_song(1, 0);

        // Song change together with note_done in WAIT
        select_song(0);
        play = 1'b1;
        expect_note(0, 0);
        note_done = 1'b1;
        expect_note(0, 1);
        song = 2'd2;
        note_done = 1'b1;
        tick();
        note_done = 1'b0;
        chk("chg_state", 32'(dut.r_state), 32'(ST_IDLE));
        chk("chg_idx", dut.r_idx, 0);
        chk("chg_song_done", song_done, 0);
        chk("chg_new_note", new_note, 0);
        expect_note(2, 0);
        run_song(2, 1);

        // Reset in the middle of the load strobe
        select_song(1);
        play = 1'b1;
        wait_note(8, lat, n, d);
        chk("mid_lat", lat, 2);
        chk("mid_strobe_seen", new_note, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_new_note", new_note, 0);
        chk("mid_rst_note", note, 0);
        chk("mid_rst_state", 32'(dut.r_state), 32'(ST_IDLE));
        song = 2'd3;
        play = 1'b0;
        tick();
        chk("mid_rst_song_q", dut.r_song_q, 3);
        reset = 1'b0;
        tick();
        chk("post_rst_idle", 32'(dut.r_state), 32'(ST_IDLE));

        // Random songs with random gaps and pauses
        for (int it = 0; it < 6; it++) begin
            int s = $urandom_range(0, SC - 1);
            select_song(s);
            run_song(s, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
